// File: rtl/pipe_muldiv_unit.sv
// pipe_muldiv_unit
//   Iterative multiply/divide unit for the EX stage. It executes MULTU, MULT,
//   DIVU and DIV into a HI/LO pair. Multiply uses radix-2 shift-add. Divide
//   uses restoring shift-subtract. Signed operations run on magnitudes, and
//   the signs are applied in the FIX cycle.
//
//   Ports
//     clk_i    rising-edge clock
//     rst_i    asynchronous reset, active low
//     start_i  issue request, sampled only in IDLE
//     op_i     00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//     src1_i   multiplicand / dividend (rs)
//     src2_i   multiplier / divisor (rt)
//     flush_i  abort the current operation (also drops a start in IDLE)
//     busy_o   high in every state except IDLE
//     done_o   one-cycle pulse while hi_o/lo_o hold a fresh result
//     dz_o     with done_o: the divide had a zero divisor
//     hi_o     product high half / remainder
//     lo_o     product low half / quotient
module pipe_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             dz_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     src1_q, src2_q;
    logic [WIDTH-1:0]     b_q;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]   acc_q;      // {partial product} or {remainder, quotient}
    logic [CW-1:0]        cnt_q;
    logic                 neg_hi_q;   // divide: remainder sign
    logic                 neg_lo_q;   // product sign or quotient sign
    logic                 dz_q;

    logic                 is_div, is_signed;
    logic                 s1, s2;
    logic [WIDTH-1:0]     mag1, mag2;
    logic                 div_zero;
    logic [WIDTH:0]       mul_sum, mul_upper;
    logic [2*WIDTH-1:0]   mul_next;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     res_hi, res_lo;

    // ------------------------------------------------------------------
    // Operand preparation
    // ------------------------------------------------------------------
    assign is_div    = op_q[1];
    assign is_signed = op_q[0];
    assign s1        = is_signed & src1_q[WIDTH-1];
    assign s2        = is_signed & src2_q[WIDTH-1];
    // Negating MIN wraps back to MIN. That value is still the correct
    // unsigned magnitude 2^(WIDTH-1).
    assign mag1      = s1 ? -src1_q : src1_q;
    assign mag2      = s2 ? -src2_q : src2_q;
    assign div_zero  = is_div && (src2_q == '0);

    // ------------------------------------------------------------------
    // One multiply step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right, carry included.
    // ------------------------------------------------------------------
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign mul_upper = acc_q[0] ? mul_sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign mul_next  = {mul_upper, acc_q[WIDTH-1:1]};

    // ------------------------------------------------------------------
    // One restoring divide step. The shifted partial remainder needs
    // WIDTH+1 bits. When the subtraction is taken, the result is below the
    // divisor, so a WIDTH-bit subtract is exact.
    // ------------------------------------------------------------------
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_sub   = div_shift[WIDTH-1:0] - b_q;
    assign div_next  = {(div_ge ? div_sub : div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], div_ge};

    // The product needs a full 2W negate so the borrow crosses the halves.
    assign prod_fix  = neg_lo_q ? -acc_q : acc_q;

    // ------------------------------------------------------------------
    // Next state and result selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        res_hi  = '0;
        res_lo  = '0;
        case (state_q)
            IDLE: begin
                if (start_i && !flush_i) state_d = PREP;
            end
            PREP: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (div_zero) begin
                    state_d = DONE;
                    res_hi  = src1_q;
                    res_lo  = '1;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flush_i)                          state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1))     state_d = FIX;
            end
            FIX: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    if (is_div) begin
                        res_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                        res_lo = neg_lo_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    end else begin
                        res_hi = prod_fix[2*WIDTH-1:WIDTH];
                        res_lo = prod_fix[WIDTH-1:0];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i && !flush_i) begin
                        op_q   <= op_i;
                        src1_q <= src1_i;
                        src2_q <= src2_i;
                    end
                end
                PREP: begin
                    neg_lo_q <= s1 ^ s2;
                    neg_hi_q <= s1;
                    dz_q     <= div_zero;
                    cnt_q    <= '0;
                    if (is_div) begin
                        b_q   <= mag2;
                        acc_q <= {{WIDTH{1'b0}}, mag1};
                    end else begin
                        b_q   <= mag1;
                        acc_q <= {{WIDTH{1'b0}}, mag2};
                    end
                end
                CALC: begin
                    acc_q <= is_div ? div_next : mul_next;
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // HI/LO change only on the edge that enters DONE.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hi_o <= '0;
            lo_o <= '0;
        end else if (state_d == DONE) begin
            hi_o <= res_hi;
            lo_o <= res_lo;
        end
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE);
    assign dz_o   = (state_q == DONE) && dz_q;

endmodule

// File: tb/tb_pipe_muldiv_unit.sv
module tb_pipe_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] s1 = '0;
    logic [31:0] s2 = '0;
    logic        flush = 1'b0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;

    pipe_muldiv_unit #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .src1_i  (s1),
        .src2_i  (s2),
        .flush_i (flush),
        .busy_o  (busy),
        .done_o  (done),
        .dz_o    (dz),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic straight from the ISA rules.
    function automatic void model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] mhi, output logic [31:0] mlo,
                                  output logic mdz, output int mlat);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        mdz  = 1'b0;
        mlat = 35;
        mhi  = '0;
        mlo  = '0;
        if (mop[1] && b == 32'd0) begin
            mhi  = a;
            mlo  = 32'hFFFF_FFFF;
            mdz  = 1'b1;
            mlat = 2;
        end else begin
            case (mop)
                2'd0: begin p = {32'd0, a} * {32'd0, b}; mhi = p[63:32]; mlo = p[31:0]; end
                2'd1: begin p = 64'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
                2'd2: begin mlo = a / b; mhi = a % b; end
                default: begin q = sa / sb; r = sa % sb; mlo = 32'(q); mhi = 32'(r); end
            endcase
        end
    endfunction

    // Issue one op. Returns the cycle in which done was seen (start edge = cycle 0),
    // or -1 if it never came within the budget.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; s1 = a; s2 = b;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic apply_and_check(input string tag, input vec_t v);
        int lat;
        run_op(v.op, v.a, v.b, lat);
        check({tag, ".lat"}, 64'(lat), 64'(v.lat));
        check({tag, ".hi"}, 64'(hi), 64'(v.hi));
        check({tag, ".lo"}, 64'(lo), 64'(v.lo));
        check({tag, ".dz"}, 64'(dz), 64'(v.dz));
    endtask

    vec_t tbl[10];

    initial begin
        vec_t v;
        int   lat, d1, d2, ndone, b36, b37;
        logic [31:0] prev_hi, prev_lo;

        tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35};
        tbl[1] = '{2'd1, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35};
        tbl[2] = '{2'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35};
        tbl[3] = '{2'd2, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 2};
        tbl[4] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 35};
        tbl[5] = '{2'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2};
        tbl[6] = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 35};
        tbl[7] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 35};
        tbl[8] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 35};
        tbl[9] = '{2'd0, 32'd0,         32'h1234_5678, 32'd0,         32'd0,         1'b0, 35};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dz",   64'(dz),   64'd0);
        check("rst.hi",   64'(hi),   64'd0);
        check("rst.lo",   64'(lo),   64'd0);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            apply_and_check($sformatf("tbl%0d", i), tbl[i]);
        end

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.a  = $urandom;
            v.b  = $urandom;
            case ($urandom_range(0, 7))
                0: v.b = 32'd0;
                1: v.b = $urandom_range(1, 15);
                2: begin v.a = 32'h8000_0000; v.b = 32'hFFFF_FFFF; end
                3: v.a = $urandom_range(0, 255);
                default: ;
            endcase
            model(v.op, v.a, v.b, v.hi, v.lo, v.dz, v.lat);
            apply_and_check($sformatf("rnd%0d", i), v);
        end

        // Flush during CALC (counter = 10) of MULTU 5*6
        run_op(2'd1, 32'hFFFF_FFF9, 32'd3, lat);
        prev_hi = 32'hFFFF_FFFF;
        prev_lo = 32'hFFFF_FFEB;
        @(negedge clk);
        start = 1'b1; op = 2'd0; s1 = 32'd5; s2 = 32'd6;
        @(posedge clk);
        ndone = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
            if (n == 12) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'd0);
        check("flush.hi", 64'(hi), 64'(prev_hi));
        check("flush.lo", 64'(lo), 64'(prev_lo));
        for (int n = 0; n < 40; n++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("flush.no_done", 64'(ndone), 64'd0);
        check("flush.hold_lo", 64'(lo), 64'(prev_lo));

        // Back-to-back DIVU 9/4 with start held high
        @(negedge clk);
        start = 1'b1; op = 2'd2; s1 = 32'd9; s2 = 32'd4;
        @(posedge clk);
        d1 = -1; d2 = -1; ndone = 0; b36 = -1; b37 = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            if (n == 36) b36 = int'(busy);
            if (n == 37) b37 = int'(busy);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = n;
                    check("b2b.lo1", 64'(lo), 64'd2);
                    check("b2b.hi1", 64'(hi), 64'd1);
                end else if (ndone == 2) begin
                    d2 = n;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("b2b.done1", 64'(d1), 64'd35);
        check("b2b.idle_gap", 64'(b36), 64'd0);
        check("b2b.restart", 64'(b37), 64'd1);
        check("b2b.done2", 64'(d2), 64'd71);
        check("b2b.ndone", 64'(ndone), 64'd2);
        check("b2b.lo2", 64'(lo), 64'd2);
        check("b2b.hi2", 64'(hi), 64'd1);

        // Asynchronous reset in CALC counter 5
        @(negedge clk);
        start = 1'b1; op = 2'd0; s1 = 32'd7; s2 = 32'd9;
        @(posedge clk);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.hi", 64'(hi), 64'd0);
        check("arst.lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2'd0, 32'd3, 32'd4, lat);
        check("arst.lat", 64'(lat), 64'd35);
        check("arst.lo12", 64'(lo), 64'd12);
        check("arst.hi0", 64'(hi), 64'd0);

        // Start while flushing in IDLE is dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'd0; s1 = 32'd2; s2 = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("idle_flush.busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
